// File: rtl/wind_light_bank.sv
// Wind-indicator light bank: calm, running and (with LIGHT_BOUNCE_EN) bouncing lamp patterns.
// Define LIGHT_BOUNCE_EN to enable bounce mode on w=11; otherwise w=11 runs left-to-right.
module wind_light_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       w,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic             step
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [WIDTH-1:0] LAMP_LSB = WIDTH'(1);
  localparam logic [WIDTH-1:0] LAMP_MSB = LAMP_LSB << (WIDTH - 1);
  localparam logic [WIDTH-1:0] CALM_A = LAMP_MSB | LAMP_LSB;
  localparam logic [WIDTH-1:0] CALM_B = (WIDTH % 2 == 1) ? (WIDTH'(1) << (WIDTH / 2))
                                                         : (WIDTH'(3) << (WIDTH / 2 - 1));

  typedef enum logic [1:0] {
    MODE_CALM   = 2'b00,
    MODE_RTL    = 2'b01,
    MODE_LTR    = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  mode_e            mode_q, mode_d;
  logic             step_q, step_d;
  mode_e            m;
  logic             adv;
`ifdef LIGHT_BOUNCE_EN
  logic             dir_q, dir_d;
`endif

  // Prescaler, effective mode selection and pattern next-state
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    mode_d = mode_q;
`ifdef LIGHT_BOUNCE_EN
    dir_d  = dir_q;
    m      = mode_e'(w);
`else
    m      = (w == 2'b11) ? MODE_LTR : mode_e'(w);
`endif
    adv    = !pause && (cnt_q == CNT_MAX);
    step_d = adv;

    if (adv) begin
      cnt_d = '0;
    end else if (!pause) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (adv && (m != mode_q)) begin
      mode_d = m;
      case (m)
        MODE_CALM: out_d = CALM_A;
        MODE_RTL:  out_d = LAMP_LSB;
        MODE_LTR:  out_d = LAMP_MSB;
`ifdef LIGHT_BOUNCE_EN
        MODE_BOUNCE: begin
          out_d = LAMP_LSB;
          dir_d = 1'b1;
        end
`endif
        default: out_d = LAMP_MSB;
      endcase
    end else if (adv) begin
      case (mode_q)
        MODE_CALM: out_d = (out_q == CALM_A) ? CALM_B : CALM_A;
        MODE_RTL:  out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        MODE_LTR:  out_d = {out_q[0], out_q[WIDTH-1:1]};
`ifdef LIGHT_BOUNCE_EN
        MODE_BOUNCE: begin
          // Reverse at either end so the lamp reflects rather than wraps
          if (dir_q && out_q[WIDTH-1]) begin
            out_d = out_q >> 1;
            dir_d = 1'b0;
          end else if (dir_q) begin
            out_d = out_q << 1;
          end else if (out_q[0]) begin
            out_d = out_q << 1;
            dir_d = 1'b1;
          end else begin
            out_d = out_q >> 1;
          end
        end
`endif
        default: out_d = out_q;
      endcase
    end
  end

  // State registers; reset dominates pause and step
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      out_q  <= LAMP_LSB;
      mode_q <= MODE_RTL;
      step_q <= 1'b0;
`ifdef LIGHT_BOUNCE_EN
      dir_q  <= 1'b1;
`endif
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      mode_q <= mode_d;
      step_q <= step_d;
`ifdef LIGHT_BOUNCE_EN
      dir_q  <= dir_d;
`endif
    end
  end

  assign out  = out_q;
  assign step = step_q;

endmodule

// File: tb/tb_wind_light_bank.sv
// Self-checking bench for wind_light_bank: three instances (8x4, 7x4, 8x1) against a lamp-position model.
module tb_wind_light_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] w;
  logic       pause;
  logic [7:0] out_a, out_c;
  logic [6:0] out_b;
  logic       step_a, step_b, step_c;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance: lamp position / calm phase rather than bit patterns
  int mcnt [3];
  int mmode[3];
  int mpos [3];
  int mdir [3];
  bit mcalm[3];
  bit mstep[3];

  always #5 clk = ~clk;

  wind_light_bank #(.WIDTH(8), .DIV(4)) dut_a (
    .clk(clk), .reset(reset), .w(w), .pause(pause), .out(out_a), .step(step_a));
  wind_light_bank #(.WIDTH(7), .DIV(4)) dut_b (
    .clk(clk), .reset(reset), .w(w), .pause(pause), .out(out_b), .step(step_b));
  wind_light_bank #(.WIDTH(8), .DIV(1)) dut_c (
    .clk(clk), .reset(reset), .w(w), .pause(pause), .out(out_c), .step(step_c));

  function automatic int wid_of(input int i);
    return (i == 1) ? 7 : 8;
  endfunction

  function automatic int div_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic logic [7:0] exp_out(input int i);
    int wd;
    int v;
    wd = wid_of(i);
    if (mmode[i] == 0) begin
      if (!mcalm[i]) v = (1 << (wd - 1)) | 1;
      else if (wd % 2 == 1) v = 1 << (wd / 2);
      else v = 3 << (wd / 2 - 1);
    end else begin
      v = 1 << mpos[i];
    end
    return 8'(v);
  endfunction

  task automatic model_tick();
    int we;
    int wd;
    we = int'(w);
`ifndef LIGHT_BOUNCE_EN
    if (we == 3) we = 2;
`endif
    for (int i = 0; i < 3; i++) begin
      wd = wid_of(i);
      if (reset) begin
        mcnt[i] = 0; mmode[i] = 1; mpos[i] = 0; mdir[i] = 1; mcalm[i] = 0; mstep[i] = 0;
      end else if (!pause && mcnt[i] == div_of(i) - 1) begin
        mstep[i] = 1;
        mcnt[i]  = 0;
        if (we != mmode[i]) begin
          mmode[i] = we;
          mcalm[i] = 0;
          mpos[i]  = (we == 2) ? wd - 1 : 0;
          if (we == 3) mdir[i] = 1;
        end else if (we == 0) begin
          mcalm[i] = !mcalm[i];
        end else if (we == 1) begin
          mpos[i] = (mpos[i] + 1) % wd;
        end else if (we == 2) begin
          mpos[i] = (mpos[i] + wd - 1) % wd;
        end else if (mdir[i] == 1) begin
          if (mpos[i] == wd - 1) begin mpos[i] = wd - 2; mdir[i] = 0; end
          else mpos[i] = mpos[i] + 1;
        end else begin
          if (mpos[i] == 0) begin mpos[i] = 1; mdir[i] = 1; end
          else mpos[i] = mpos[i] - 1;
        end
      end else begin
        mstep[i] = 0;
        if (!pause) mcnt[i] = mcnt[i] + 1;
      end
    end
  endtask

  // One clock: model updates with the DUT at the edge, outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset(input logic [1:0] wv);
    reset = 1'b1; w = wv; pause = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; w = 2'b01; pause = 1'b0;
    tick(); tick();
    n_checks++; if (out_a !== 8'h01) $display("FAIL reset_out_a got %h want 01", out_a); else n_pass++;
    n_checks++; if (step_a !== 1'b0) $display("FAIL reset_step_a got %b want 0", step_a); else n_pass++;
    n_checks++; if (out_b !== 7'h01) $display("FAIL reset_out_b got %h want 01", out_b); else n_pass++;
    n_checks++; if (out_c !== 8'h01 || step_c !== 1'b0)
      $display("FAIL reset_c got out=%h step=%b want out=01 step=0", out_c, step_c); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_rtl();
    int steps = 0;
    do_reset(2'b01);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (step_a === 1'b1) steps++;
      if (c == 3) begin
        n_checks++; if (out_a !== 8'h02 || step_a !== 1'b1)
          $display("FAIL rtl_first_step got out=%h step=%b want out=02 step=1", out_a, step_a); else n_pass++;
      end
      n_checks++; if (out_a !== exp_out(0)) $display("FAIL rtl_out cyc %0d got %h want %h", c, out_a, exp_out(0)); else n_pass++;
      n_checks++; if (step_a !== mstep[0]) $display("FAIL rtl_step cyc %0d got %b want %b", c, step_a, mstep[0]); else n_pass++;
    end
    n_checks++; if (steps != 10) $display("FAIL rtl_step_count got %0d want 10", steps); else n_pass++;
    n_checks++; if (out_a !== 8'h04) $display("FAIL rtl_wrap got %h want 04", out_a); else n_pass++;
  endtask

  task automatic test_ltr();
    do_reset(2'b10);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 3) begin
        n_checks++; if (out_a !== 8'h80) $display("FAIL ltr_load got %h want 80", out_a); else n_pass++;
      end
      n_checks++; if (out_a !== exp_out(0)) $display("FAIL ltr_out cyc %0d got %h want %h", c, out_a, exp_out(0)); else n_pass++;
      n_checks++; if ({1'b0, out_b} !== exp_out(1)) $display("FAIL ltr_out_b cyc %0d got %h want %h", c, out_b, exp_out(1)); else n_pass++;
    end
  endtask

  task automatic test_calm();
    do_reset(2'b00);
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c == 7) begin
        n_checks++; if (out_a !== 8'h18) $display("FAIL calm_b8 got %h want 18", out_a); else n_pass++;
        n_checks++; if (out_b !== 7'h08) $display("FAIL calm_b7 got %h want 08", out_b); else n_pass++;
      end
      n_checks++; if (out_a !== exp_out(0)) $display("FAIL calm_out cyc %0d got %h want %h", c, out_a, exp_out(0)); else n_pass++;
      n_checks++; if ({1'b0, out_b} !== exp_out(1)) $display("FAIL calm_out_b cyc %0d got %h want %h", c, out_b, exp_out(1)); else n_pass++;
    end
    tick(); tick();
    w = 2'b01;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++; if (out_a !== exp_out(0)) $display("FAIL calm_switch cyc %0d got %h want %h", c, out_a, exp_out(0)); else n_pass++;
      n_checks++; if ({1'b0, out_b} !== exp_out(1)) $display("FAIL calm_switch_b cyc %0d got %h want %h", c, out_b, exp_out(1)); else n_pass++;
    end
  endtask

  task automatic test_pause();
    logic [7:0] held;
    int guard = 0;
    do_reset(2'b01);
    tick(); tick(); tick(); tick();
    while (mcnt[0] != 2 && guard < 8) begin tick(); guard++; end
    n_checks++; if (mcnt[0] != 2) $display("FAIL pause_align got cnt %0d want 2", mcnt[0]); else n_pass++;
    held = out_a;
    pause = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++; if (out_a !== held || step_a !== 1'b0)
        $display("FAIL pause_hold cyc %0d got out=%h step=%b want out=%h step=0", c, out_a, step_a, held); else n_pass++;
    end
    pause = 1'b0;
    tick();
    n_checks++; if (step_a !== 1'b0 || out_a !== held)
      $display("FAIL pause_resume1 got out=%h step=%b want out=%h step=0", out_a, step_a, held); else n_pass++;
    tick();
    n_checks++; if (step_a !== 1'b1 || out_a !== exp_out(0))
      $display("FAIL pause_resume2 got out=%h step=%b want out=%h step=1", out_a, step_a, exp_out(0)); else n_pass++;
    tick(); tick();
    pause = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    n_checks++; if (out_a !== 8'h01 || step_a !== 1'b0)
      $display("FAIL pause_reset got out=%h step=%b want out=01 step=0", out_a, step_a); else n_pass++;
    reset = 1'b0; pause = 1'b0;
  endtask

  task automatic test_div1();
    logic [7:0] prev;
    do_reset(2'b01);
    prev = out_c;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++; if (step_c !== 1'b1 || out_c === prev)
        $display("FAIL div1_step cyc %0d got out=%h step=%b want changed out, step=1", c, out_c, step_c); else n_pass++;
      n_checks++; if (out_c !== exp_out(2)) $display("FAIL div1_out cyc %0d got %h want %h", c, out_c, exp_out(2)); else n_pass++;
      prev = out_c;
    end
    reset = 1'b1;
    tick();
    n_checks++; if (out_c !== 8'h01 || step_c !== 1'b0)
      $display("FAIL div1_reset got out=%h step=%b want out=01 step=0", out_c, step_c); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_bounce();
    do_reset(2'b11);
    for (int c = 0; c < 64; c++) begin
      tick();
      if (c == 35) begin
`ifdef LIGHT_BOUNCE_EN
        n_checks++; if (out_a !== 8'h40) $display("FAIL bounce_reflect got %h want 40", out_a); else n_pass++;
`else
        n_checks++; if (out_a !== 8'h80) $display("FAIL bounce_as_ltr got %h want 80", out_a); else n_pass++;
`endif
      end
      n_checks++; if (out_a !== exp_out(0)) $display("FAIL bounce_out cyc %0d got %h want %h", c, out_a, exp_out(0)); else n_pass++;
      n_checks++; if ({1'b0, out_b} !== exp_out(1)) $display("FAIL bounce_out_b cyc %0d got %h want %h", c, out_b, exp_out(1)); else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset(2'b01);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) w = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++; if (out_a !== exp_out(0) || step_a !== mstep[0])
        $display("FAIL rand_a cyc %0d got out=%h step=%b want out=%h step=%b", c, out_a, step_a, exp_out(0), mstep[0]); else n_pass++;
      n_checks++; if ({1'b0, out_b} !== exp_out(1) || step_b !== mstep[1])
        $display("FAIL rand_b cyc %0d got out=%h step=%b want out=%h step=%b", c, out_b, step_b, exp_out(1), mstep[1]); else n_pass++;
      n_checks++; if (out_c !== exp_out(2) || step_c !== mstep[2])
        $display("FAIL rand_c cyc %0d got out=%h step=%b want out=%h step=%b", c, out_c, step_c, exp_out(2), mstep[2]); else n_pass++;
    end
    reset = 1'b0; pause = 1'b0;
  endtask

  initial begin
    reset = 1'b1; w = 2'b01; pause = 1'b0;
    #1;
    test_reset();
    test_rtl();
    test_ltr();
    test_calm();
    test_pause();
    test_div1();
    test_bounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wind_light_bank.md
# wind_light_bank

Parametrised wind-indicator light bank for the lighting subsystem. Drives a WIDTH-lamp row with a calm pattern, a right-to-left or left-to-right running light, and an optional bouncing light, selected by a 2-bit wind code. A built-in prescaler sets the step rate. A pause input freezes the display. The block generalises the fixed 3-lamp wind-light FSM to any lamp count.

## Interface
- WIDTH, 8, lamp count; legal range is WIDTH >= 3.
- DIV, 4, clk cycles per pattern step; legal range is DIV >= 1.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clock clk.
- w  input  2  wind code: 00 calm, 01 right-to-left, 10 left-to-right, 11 bounce (see Configuration).
- pause  input  1  while high, the prescaler and the pattern hold.
- out  output  WIDTH  lamp drive; bit 0 is the rightmost lamp.
- step  output  1  one-cycle pulse, high in the same cycle that out takes a new value.

## Operation
- State registers:
  - cnt, the prescaler, width clog2(DIV), minimum 1.
  - out.
  - mode_q, 2 bits: the effective mode of the last step.
  - dir, 1 bit: bounce direction, 1 = up toward the MSB.
- Effective mode m: equal to w, except that w=11 maps to 10 when bounce is compiled out.
- Step condition adv: !pause && cnt == DIV-1.
  - When adv is true, cnt returns to 0. Otherwise cnt increments if !pause and holds if pause.
- Patterns:
  - CALM_A has the MSB and LSB set.
  - CALM_B has the centre lamp set: bit WIDTH/2 for odd WIDTH, bits WIDTH/2 and WIDTH/2-1 for even WIDTH.
- Mode change: on adv with m != mode_q, out loads the start pattern of m and mode_q <= m.
  - 00 -> CALM_A.
  - 01 -> bit 0 only.
  - 10 -> bit WIDTH-1 only.
  - 11 -> bit 0 only, with dir <= 1.
- Same mode: on adv with m == mode_q:
  - 00: out toggles between CALM_A and CALM_B. Any other value loads CALM_A.
  - 01: rotate left by 1; bit WIDTH-1 wraps to bit 0.
  - 10: rotate right by 1; bit 0 wraps to bit WIDTH-1.
  - 11: if dir=1 and out[WIDTH-1]=1, shift right and set dir <= 0. Else if dir=1, shift left. If dir=0 and out[0]=1, shift left and set dir <= 1. Else if dir=0, shift right.
- out is never all-zero. Rotation is a pure rotate, so it preserves one-hot.
- step <= adv, registered.

## Timing
- Reset values:
  - out = 1 (bit 0).
  - mode_q = 01.
  - cnt = 0.
  - dir = 1.
  - step = 0.
- Reset has priority over pause and adv. A reset asserted mid-pattern restores the reset values on the next edge.
- First step after reset: the out update occurs at the edge ending cycle DIV-1 after reset deassertion, provided pause stays low.
- w is sampled only on the cycle where adv is true. A w change between steps takes effect at the next step, and that step is the mode-change load.
- DIV=1: adv equals !pause, so out can change every cycle.
- Pause behaviour:
  - Rising pause: freezes cnt mid-count. Falling pause resumes the count from the frozen value.
  - If pause is high on a cycle where cnt == DIV-1, no step occurs.
- step and out both update at the same edge. There is zero additional latency between the two.

## Configuration
- LIGHT_BOUNCE_EN.
- Defined: w=11 selects bounce mode and the dir register exists.
- Undefined: w=11 behaves exactly as 10 (mode_q records 10), and dir is not implemented.

## Test plan
All scenarios use WIDTH=8, DIV=4, pause=0 unless noted.
- Reset, w=01 -> out=01, step=0. Then steps every 4 cycles: 02, 04, … 80, 01 (wrap). step pulses once per 4 cycles.
- From reset, w=10 -> first step loads 80 (mode change). Subsequent steps: 40, 20, … 01, 80 (wrap).
- w=00 from reset -> steps: 81, 18, 81, 18. Then switch w=01 mid-count -> the next step loads 01, the one after gives 02. Repeat with WIDTH=7: CALM_B=08.
- pause: hold pause high for 10 cycles at cnt=2 -> out and cnt frozen, step=0. After release, the step occurs 2 cycles later (cnt 2->3 then adv). Assert reset mid-pause -> out=01 on the next edge.
- DIV=1, w=01 -> out changes every cycle and step is held high. Then reset while stepping -> out=01, step=0.
- LIGHT_BOUNCE_EN defined, w=11 -> 01, 02, … 80, 40, … 01, 02. Undefined -> w=11 produces the same sequence as w=10.
